// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : Memory stage of the five-stage core. Issues data-bus requests for
//            loads and stores, aligns store data / byte enables, extracts and
//            extends load data, and produces the MEM/WB pipeline register.
//            Stalls upstream while a bus transaction is outstanding.
// Options  : MEM_MISALIGN_TRAP_EN - flag misaligned half/word accesses, suppress
//            the bus request and write a W bubble instead.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wrM,
  input  logic [1:0]  wb_selM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  waddrM,
  input  logic [6:0]  instr_opcodeM,
  input  logic [31:0] AddrM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] SrcB_forwardM,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        stall_mem,
  output logic        misalign,
  output logic        reg_wrW,
  output logic [1:0]  wb_selW,
  output logic [4:0]  waddrW,
  output logic [31:0] AddrW,
  output logic [31:0] ALUResultW,
  output logic [31:0] rdataW
);

  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;

  localparam logic [0:0] c_S_IDLE = 1'b0;
  localparam logic [0:0] c_S_WAIT = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_memop;
  logic        w_mis;
  logic        w_req;
  logic        w_stall;
  logic        w_done;
  logic        w_latch;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ldata;

  assign w_is_load  = (instr_opcodeM == c_OP_LOAD);
  assign w_is_store = (instr_opcodeM == c_OP_STORE);
  assign w_memop    = w_is_load | w_is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  // Misalignment check: half accesses need addr[0]=0, word accesses addr[1:0]=0.
  // Only evaluated in IDLE; a load sitting in WAIT was already found aligned.
  always_comb begin
    w_mis = 1'b0;
    if (w_memop && (r_state == c_S_IDLE)) begin
      case (funct3M[1:0])
        2'b01:   w_mis = ALUResultM[0];
        2'b10:   w_mis = |ALUResultM[1:0];
        default: w_mis = 1'b0;
      endcase
    end
  end
`else
  assign w_mis = 1'b0;
`endif

  // State register: IDLE issues requests, WAIT holds for load data.
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: a granted load waits for rvalid; a stray gnt in WAIT is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (w_is_load && !w_mis && dbus_gnt) w_state_nxt = c_S_WAIT;
      c_S_WAIT: if (dbus_rvalid)                      w_state_nxt = c_S_IDLE;
      default:  w_state_nxt = c_S_IDLE;
    endcase
  end

  // FSM outputs: w_done means the M instruction retires into W this cycle.
  always_comb begin
    w_req   = 1'b0;
    w_done  = 1'b0;
    w_stall = 1'b0;
    w_latch = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        if (!w_memop) begin
          w_done = 1'b1;
        end else if (!w_mis) begin
          w_req = 1'b1;
          if (w_is_store && dbus_gnt) begin
            w_done = 1'b1;
          end else begin
            w_stall = 1'b1;
            w_latch = w_is_load & dbus_gnt;
          end
        end
      end
      c_S_WAIT: begin
        if (dbus_rvalid) w_done  = 1'b1;
        else             w_stall = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture size/sign and byte offset of a granted load for later extraction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f3  <= 3'd0;
      r_off <= 2'd0;
    end else if (w_latch) begin
      r_f3  <= funct3M;
      r_off <= ALUResultM[1:0];
    end
  end

  // Store lane replication and byte enables from the low address bits.
  always_comb begin
    w_wdata = SrcB_forwardM;
    w_be    = 4'b1111;
    case (funct3M[1:0])
      2'b00: begin
        w_wdata = {4{SrcB_forwardM[7:0]}};
        w_be    = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        w_wdata = {2{SrcB_forwardM[15:0]}};
        w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = SrcB_forwardM;
        w_be    = 4'b1111;
      end
    endcase
  end

  // Bus outputs are forced to zero outside an active request and during reset.
  assign dbus_req   = w_req & ~rst;
  assign dbus_we    = dbus_req & w_is_store;
  assign dbus_addr  = dbus_req ? {ALUResultM[31:2], 2'b00} : 32'd0;
  assign dbus_wdata = dbus_we ? w_wdata : 32'd0;
  assign dbus_be    = dbus_we ? w_be : 4'b0000;
  assign stall_mem  = w_stall & ~rst;
  assign misalign   = w_mis & ~rst;

  // Load extraction: pick the lane by latched offset, then sign/zero extend.
  always_comb begin
    w_byte  = dbus_rdata[{r_off, 3'b000} +: 8];
    w_half  = r_off[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (r_f3[1:0])
      2'b00:   w_ldata = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
      2'b01:   w_ldata = {{16{~r_f3[2] & w_half[15]}}, w_half};
      default: w_ldata = dbus_rdata;
    endcase
  end

  // MEM/WB register: retiring instructions pass through, everything else is a bubble.
  always_ff @(posedge clk) begin
    if (rst || !w_done) begin
      reg_wrW    <= 1'b0;
      wb_selW    <= 2'd0;
      waddrW     <= 5'd0;
      AddrW      <= 32'd0;
      ALUResultW <= 32'd0;
      rdataW     <= 32'd0;
    end else begin
      reg_wrW    <= reg_wrM;
      wb_selW    <= wb_selM;
      waddrW     <= waddrM;
      AddrW      <= AddrM;
      ALUResultW <= ALUResultM;
      rdataW     <= (r_state == c_S_WAIT) ? w_ldata : 32'd0;
    end
  end

endmodule
`default_nettype wire
